des_block_dma: RTL and testbench
================================

Name: des_block_dma

Overview:
Sequencer that streams 64-bit plaintext blocks from SDRAM through the 3DES core and writes the ciphertext back to SDRAM.
- Owns one Avalon-MM master port.
- Configured by the CSR slave: source address, destination address, block count, start.
- For each block: two 32-bit reads, assemble, pulse the DES start, wait for DES done, two 32-bit writes.
- Replaces ad-hoc read/FIFO sequencing in the master/slave wrapper with a single block-at-a-time engine.

Parameters:
ADDRW, 26, Avalon master address width (byte address)
DATAW, 32, Avalon data width (fixed 32; two beats per DES block)
CNTW, 16, width of block count and progress counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle pulse; launch transfer (ignored while busy)
cfg_abort  in  1  level; stop at next block boundary
cfg_src_addr  in  ADDRW  source byte address, 8-byte aligned
cfg_dst_addr  in  ADDRW  destination byte address, 8-byte aligned
cfg_num_blocks  in  CNTW  number of 64-bit blocks
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
aborted  out  1  sticky until next start; set if transfer ended via cfg_abort
blocks_done  out  CNTW  blocks fully written back in the current transfer
des_data_out  out  64  plaintext block to DES, stable from des_start until des_done
des_start  out  1  one-cycle pulse
des_done  in  1  pulse; des_result is valid this cycle
des_result  in  64  ciphertext block
master_address  out  ADDRW  Avalon address
master_read  out  1  Avalon read
master_write  out  1  Avalon write
master_writedata  out  32  Avalon write data
master_readdata  in  32  Avalon read data
master_readdatavalid  in  1  Avalon read data valid
master_waitrequest  in  1  Avalon wait request

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; internal src/dst pointers, count and result register 0. Reset mid-transfer drops any bus request the same cycle, with no completion.
- States: IDLE, RD_HI, RD_HI_W, RD_LO, RD_LO_W, DES_GO, DES_W, WR_HI, WR_LO, NEXT.
- IDLE: on cfg_start:
  - Latch src, dst and num; clear blocks_done and aborted; busy=1.
  - If num==0, go to NEXT with no bus traffic.
  - Otherwise go to RD_HI.
- RD_HI/RD_LO: master_read=1, address=src (RD_HI) or src+4 (RD_LO).
  - Address and read are held constant while waitrequest=1.
  - On waitrequest=0, advance to the matching _W state.
- RD_HI_W/RD_LO_W: wait for readdatavalid, then capture readdata.
  - Word at the lower address becomes bits [63:32].
  - readdatavalid in any other state is ignored.
- Only one read is outstanding at a time.
- DES_GO: des_start=1 for exactly one cycle; des_data_out already holds the assembled block; go to DES_W.
- DES_W: on des_done, capture des_result and go to WR_HI. des_done in any other state is ignored. There is no timeout.
- WR_HI: write des_result[63:32] to dst. WR_LO: write des_result[31:0] to dst+4.
  - write, address and writedata are held while waitrequest=1.
  - On acceptance in WR_LO: blocks_done+1, src+=8, dst+=8; go to NEXT.
- NEXT:
  - If blocks_done==num: done=1, busy=0, go to IDLE.
  - Else if cfg_abort=1: done=1, aborted=1, busy=0, go to IDLE.
  - Else go to RD_HI.
- cfg_abort never truncates a block in flight.
- Address arithmetic is modulo 2^ADDRW (wrap silently). Low 3 bits of cfg addresses are forced to 0.
- cfg_start while busy is ignored, including on the same cycle as done.
- Minimum per block with waitrequest=0 and readdatavalid one cycle after acceptance is 9 cycles + DES latency.
- master_read and master_write are never high together.

Test Plan:
- 1 block, src=0x0100000, dst=0x0200000, mem[src]=0x01234567, mem[src+4]=0x89ABCDEF; DES model returns 0xDEADBEEFCAFEF00D → des_data_out=0x0123456789ABCDEF at the des_start pulse; writes 0xDEADBEEF@0x0200000 and 0xCAFEF00D@0x0200004; single done pulse; blocks_done=1; busy low after.
- waitrequest held 3 cycles on every read and write → address/data/strobe stable throughout; exactly 2 reads + 2 writes per block; no duplicate captures.
- num_blocks=0 → done pulses 2 cycles after start; master_read/master_write never asserted; blocks_done=0.
- 3 blocks, src=0x0000010 → read addresses 0x10,0x14,0x18,0x1C,0x20,0x24; writes likewise from dst; blocks_done ends at 3.
- cfg_abort raised during DES_W of block 1 of 4 → block 1 is written back; done with aborted=1; blocks_done=1. cfg_start while busy and a spurious des_done in IDLE → no effect.
- reset asserted during WR_HI → master_write=0 and busy=0 immediately; after release a new start runs normally from IDLE.

Source files
------------

// File: rtl/des_block_dma.sv
// des_block_dma: block-at-a-time sequencer that streams 64-bit plaintext
// blocks from SDRAM through the 3DES core and writes the ciphertext back.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cfg_start             one-cycle launch pulse (ignored while busy)
//   cfg_abort             level; stop at the next block boundary
//   cfg_src_addr/dst_addr 8-byte aligned byte addresses (low 3 bits ignored)
//   cfg_num_blocks        number of 64-bit blocks to process
//   busy, done, aborted   transfer status (done is a one-cycle pulse)
//   blocks_done           blocks fully written back in this transfer
//   des_data_out/start    plaintext block and start pulse to the DES core
//   des_done/result       completion pulse and ciphertext from the DES core
//   master_*              Avalon-MM master (one read outstanding at a time)
module des_block_dma #(
    parameter int ADDRW = 26,
    parameter int DATAW = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [ADDRW-1:0] cfg_src_addr,
    input  logic [ADDRW-1:0] cfg_dst_addr,
    input  logic [CNTW-1:0]  cfg_num_blocks,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNTW-1:0]  blocks_done,
    output logic [63:0]      des_data_out,
    output logic             des_start,
    input  logic             des_done,
    input  logic [63:0]      des_result,
    output logic [ADDRW-1:0] master_address,
    output logic             master_read,
    output logic             master_write,
    output logic [DATAW-1:0] master_writedata,
    input  logic [DATAW-1:0] master_readdata,
    input  logic             master_readdatavalid,
    input  logic             master_waitrequest
);

    typedef enum logic [3:0] {
        IDLE, RD_HI, RD_HI_W, RD_LO, RD_LO_W, DES_GO, DES_W, WR_HI, WR_LO, NEXT
    } state_t;

    localparam logic [ADDRW-1:0] ALIGN_MASK = ~ADDRW'(7);
    localparam logic [ADDRW-1:0] WORD_STEP  = ADDRW'(4);
    localparam logic [ADDRW-1:0] BLOCK_STEP = ADDRW'(8);

    state_t           state;
    logic [ADDRW-1:0] src_ptr;
    logic [ADDRW-1:0] dst_ptr;
    logic [CNTW-1:0]  num_blocks;
    logic [63:0]      result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            src_ptr          <= '0;
            dst_ptr          <= '0;
            num_blocks       <= '0;
            result           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            blocks_done      <= '0;
            des_data_out     <= '0;
            des_start        <= 1'b0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            done      <= 1'b0;
            des_start <= 1'b0;
            case (state)
                IDLE: begin
                    // done is high only in the first IDLE cycle after a
                    // transfer; a start coinciding with it is dropped.
                    if (cfg_start && !done) begin
                        src_ptr     <= cfg_src_addr & ALIGN_MASK;
                        dst_ptr     <= cfg_dst_addr & ALIGN_MASK;
                        num_blocks  <= cfg_num_blocks;
                        blocks_done <= '0;
                        aborted     <= 1'b0;
                        busy        <= 1'b1;
                        if (cfg_num_blocks == '0) begin
                            state <= NEXT;
                        end else begin
                            master_read    <= 1'b1;
                            master_address <= cfg_src_addr & ALIGN_MASK;
                            state          <= RD_HI;
                        end
                    end
                end
                RD_HI: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= RD_HI_W;
                    end
                end
                RD_HI_W: begin
                    // Lower-address word is the high half of the DES block.
                    if (master_readdatavalid) begin
                        des_data_out[63:32] <= master_readdata;
                        master_read         <= 1'b1;
                        master_address      <= src_ptr + WORD_STEP;
                        state               <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= RD_LO_W;
                    end
                end
                RD_LO_W: begin
                    if (master_readdatavalid) begin
                        des_data_out[31:0] <= master_readdata;
                        des_start          <= 1'b1;
                        state              <= DES_GO;
                    end
                end
                DES_GO: begin
                    state <= DES_W;
                end
                DES_W: begin
                    if (des_done) begin
                        result           <= des_result;
                        master_write     <= 1'b1;
                        master_address   <= dst_ptr;
                        master_writedata <= des_result[63:32];
                        state            <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (!master_waitrequest) begin
                        master_address   <= dst_ptr + WORD_STEP;
                        master_writedata <= result[31:0];
                        state            <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        blocks_done  <= blocks_done + CNTW'(1);
                        src_ptr      <= src_ptr + BLOCK_STEP;
                        dst_ptr      <= dst_ptr + BLOCK_STEP;
                        state        <= NEXT;
                    end
                end
                NEXT: begin
                    // Completion takes priority over abort, so an abort that
                    // arrives during the last block still ends as a normal run.
                    if (blocks_done == num_blocks) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cfg_abort) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        master_read    <= 1'b1;
                        master_address <= src_ptr;
                        state          <= RD_HI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_block_dma.sv
// tb_des_block_dma: self-checking bench for des_block_dma with an Avalon
// memory responder, a DES core stand-in and a block-level reference model.
module tb_des_block_dma;

    logic        clk;
    logic        reset;
    logic        cfg_start;
    logic        cfg_abort;
    logic [25:0] cfg_src_addr;
    logic [25:0] cfg_dst_addr;
    logic [15:0] cfg_num_blocks;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] blocks_done;
    logic [63:0] des_data_out;
    logic        des_start;
    logic        des_done;
    logic [63:0] des_result;
    logic [25:0] master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    des_block_dma #(.ADDRW(26), .DATAW(32), .CNTW(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
        .cfg_num_blocks(cfg_num_blocks),
        .busy(busy), .done(done), .aborted(aborted), .blocks_done(blocks_done),
        .des_data_out(des_data_out), .des_start(des_start),
        .des_done(des_done), .des_result(des_result),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_waitrequest(master_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [25:0] src;
        logic [25:0] dst;
        int          num;
        int          ws;
        int          lat;
        int          abort_after;
        bit          poke;
        int          exp_blocks;
        bit          exp_aborted;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Shared knobs, each written by the main thread only.
    int          ws       = 0;
    int          des_lat  = 0;
    logic [31:0] mem_salt = 32'h0;
    int          spur_req = 0;

    // Logs, each written by exactly one process.
    logic [25:0] rd_log[$];
    logic [25:0] wr_a_log[$];
    logic [31:0] wr_d_log[$];
    logic [63:0] pt_log[$];
    int done_cnt  = 0;
    int start_cnt = 0;
    int stab_err  = 0;
    int overlap   = 0;
    int des_err   = 0;
    int spur_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source memory contents: two fixed words for the known-answer block,
    // a salted hash of the address everywhere else.
    function automatic logic [31:0] memrd(input logic [25:0] a);
        if (a == 26'h0100000) return 32'h01234567;
        if (a == 26'h0100004) return 32'h89ABCDEF;
        return (32'(a) * 32'h9E3779B1) ^ mem_salt;
    endfunction

    function automatic logic [63:0] des_f(input logic [63:0] p);
        if (p == 64'h0123456789ABCDEF) return 64'hDEADBEEFCAFEF00D;
        return {p[31:0] ^ 32'hA5A50F0F, p[63:32] + 32'h13579BDF};
    endfunction

    // Avalon responder: fixed wait states per transaction, read data one
    // cycle after acceptance, random junk on readdatavalid when idle.
    initial begin
        int          wcnt;
        bit          pend;
        bit          last_wait;
        logic [31:0] pend_data;
        logic [25:0] sv_addr;
        logic [31:0] sv_data;
        logic        sv_rd;
        logic        sv_wr;
        wcnt = 0; pend = 0; last_wait = 0; pend_data = '0;
        sv_addr = '0; sv_data = '0; sv_rd = 0; sv_wr = 0;
        master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                master_waitrequest = 1'b0;
                master_readdatavalid = 1'b0;
                wcnt = 0; pend = 0; last_wait = 0;
                continue;
            end
            if (pend) begin
                master_readdatavalid = 1'b1;
                master_readdata = pend_data;
                pend = 0;
            end else begin
                master_readdatavalid = ($urandom_range(0, 3) == 0);
                master_readdata = $urandom;
            end
            if (last_wait) begin
                if (master_read !== sv_rd || master_write !== sv_wr || master_address !== sv_addr ||
                    (sv_wr && master_writedata !== sv_data))
                    stab_err++;
            end
            if (master_read && master_write) overlap++;
            last_wait = 0;
            if (master_read || master_write) begin
                if (wcnt < ws) begin
                    master_waitrequest = 1'b1;
                    wcnt++;
                    last_wait = 1;
                    sv_rd = master_read; sv_wr = master_write;
                    sv_addr = master_address; sv_data = master_writedata;
                end else begin
                    master_waitrequest = 1'b0;
                    wcnt = 0;
                    if (master_read) begin
                        rd_log.push_back(master_address);
                        pend = 1;
                        pend_data = memrd(master_address);
                    end else begin
                        wr_a_log.push_back(master_address);
                        wr_d_log.push_back(master_writedata);
                    end
                end
            end else begin
                master_waitrequest = 1'b0;
            end
        end
    end

    // DES core stand-in with programmable latency.
    initial begin
        bit          des_pend;
        int          des_cnt;
        logic [63:0] pt_hold;
        des_pend = 0; des_cnt = 0; pt_hold = '0;
        des_done = 1'b0;
        des_result = '0;
        forever begin
            @(negedge clk);
            des_done = 1'b0;
            if (reset) begin
                des_pend = 0;
            end else if (spur_req != spur_done) begin
                des_done = 1'b1;
                des_result = 64'hBADBADBADBADBAD0;
                spur_done++;
            end else if (des_pend) begin
                if (des_cnt == 0) begin
                    if (des_data_out !== pt_hold) des_err++;
                    des_done = 1'b1;
                    des_result = des_f(pt_hold);
                    des_pend = 0;
                end else begin
                    des_cnt--;
                end
            end else if (des_start) begin
                des_pend = 1;
                pt_hold = des_data_out;
                des_cnt = des_lat;
            end
        end
    end

    // Pulse monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) done_cnt++;
                if (des_start) begin
                    start_cnt++;
                    pt_log.push_back(des_data_out);
                end
            end
        end
    end

    // Runs one transfer from the current negedge and checks it against the
    // block-level model: block i reads src+8i, src+8i+4 and writes the DES
    // result of the assembled block to dst+8i, dst+8i+4.
    task automatic do_xfer(input vec_t v, input int idx);
        int          rb, wb, pb, db, sb;
        bit          seen, drop;
        logic [25:0] sa, da;
        logic [63:0] pt, ct;
        rb = rd_log.size(); wb = wr_a_log.size(); pb = pt_log.size();
        db = done_cnt; sb = start_cnt;
        ws = v.ws; des_lat = v.lat;
        cfg_src_addr = v.src; cfg_dst_addr = v.dst; cfg_num_blocks = 16'(v.num);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        seen = 0; drop = 0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (v.abort_after > 0 && (start_cnt - sb) >= v.abort_after) cfg_abort = 1'b1;
            if (v.poke && cyc == 6) begin
                cfg_start = 1'b1;
                cfg_src_addr = 26'h3000000;
                cfg_num_blocks = 16'd7;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1;
            else if (!busy) drop = 1;
        end
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check($sformatf("v%0d_timeout", idx), 64'(seen), 64'd1);
        check($sformatf("v%0d_busy_held", idx), 64'(drop), 64'd0);
        check($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_blocks_done", idx), 64'(blocks_done), 64'(v.exp_blocks));
        check($sformatf("v%0d_aborted", idx), 64'(aborted), 64'(v.exp_aborted));
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
        check($sformatf("v%0d_idle_after", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_done_cnt", idx), 64'(done_cnt - db), 64'd1);
        check($sformatf("v%0d_nrd", idx), 64'(rd_log.size() - rb), 64'(2 * v.exp_blocks));
        check($sformatf("v%0d_nwr", idx), 64'(wr_a_log.size() - wb), 64'(2 * v.exp_blocks));
        check($sformatf("v%0d_npt", idx), 64'(pt_log.size() - pb), 64'(v.exp_blocks));
        for (int i = 0; i < v.exp_blocks; i++) begin
            sa = (v.src & 26'h3FFFFF8) + 26'(8 * i);
            da = (v.dst & 26'h3FFFFF8) + 26'(8 * i);
            pt = {memrd(sa), memrd(sa + 26'd4)};
            ct = des_f(pt);
            if (rb + 2 * i + 1 < rd_log.size()) begin
                check($sformatf("v%0d_rd%0d_hi", idx, i), 64'(rd_log[rb + 2 * i]), 64'(sa));
                check($sformatf("v%0d_rd%0d_lo", idx, i), 64'(rd_log[rb + 2 * i + 1]), 64'(sa + 26'd4));
            end
            if (pb + i < pt_log.size())
                check($sformatf("v%0d_pt%0d", idx, i), pt_log[pb + i], pt);
            if (wb + 2 * i + 1 < wr_a_log.size()) begin
                check($sformatf("v%0d_wa%0d_hi", idx, i), 64'(wr_a_log[wb + 2 * i]), 64'(da));
                check($sformatf("v%0d_wd%0d_hi", idx, i), 64'(wr_d_log[wb + 2 * i]), 64'(ct[63:32]));
                check($sformatf("v%0d_wa%0d_lo", idx, i), 64'(wr_a_log[wb + 2 * i + 1]), 64'(da + 26'd4));
                check($sformatf("v%0d_wd%0d_lo", idx, i), 64'(wr_d_log[wb + 2 * i + 1]), 64'(ct[31:0]));
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        int   rb, wb;
        bit   seen;
        vec_t rv;

        vecs[0] = '{26'h0100000, 26'h0200000, 1, 0, 2, 0, 0, 1, 0};
        vecs[1] = '{26'h0100000, 26'h0200000, 1, 3, 1, 0, 0, 1, 0};
        vecs[2] = '{26'h0000010, 26'h0000400, 3, 0, 0, 0, 0, 3, 0};
        vecs[3] = '{26'h0000013, 26'h0000807, 2, 1, 3, 0, 0, 2, 0};
        vecs[4] = '{26'h3FFFFF8, 26'h3FFFFF0, 2, 0, 1, 0, 0, 2, 0};
        vecs[5] = '{26'h0001000, 26'h0002000, 4, 0, 5, 1, 1, 1, 1};
        vecs[6] = '{26'h0003000, 26'h0004000, 3, 2, 5, 2, 0, 2, 1};
        vecs[7] = '{26'h0005000, 26'h0006000, 2, 0, 5, 2, 0, 2, 0};

        reset = 1'b1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_src_addr = '0; cfg_dst_addr = '0; cfg_num_blocks = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_blocks", 64'(blocks_done), 64'd0);
        check("rst_rd", 64'(master_read), 64'd0);
        check("rst_wr", 64'(master_write), 64'd0);
        check("rst_addr", 64'(master_address), 64'd0);
        check("rst_des_start", 64'(des_start), 64'd0);
        check("rst_des_data", des_data_out, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i], i);
            if (i == 0 && wr_d_log.size() >= 2 && pt_log.size() >= 1) begin
                check("kat_pt", pt_log[0], 64'h0123456789ABCDEF);
                check("kat_wd_hi", 64'(wr_d_log[0]), 64'hDEADBEEF);
                check("kat_wd_lo", 64'(wr_d_log[1]), 64'hCAFEF00D);
            end
        end

        // Zero-length transfer: done two cycles after start, no bus traffic.
        ws = 0;
        rb = rd_log.size(); wb = wr_a_log.size();
        cfg_num_blocks = 16'd0; cfg_src_addr = 26'h0000100;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy_end", 64'(busy), 64'd0);
        check("zero_blocks", 64'(blocks_done), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_nrd", 64'(rd_log.size() - rb), 64'd0);
        check("zero_nwr", 64'(wr_a_log.size() - wb), 64'd0);

        // Spurious des_done while idle.
        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_done", 64'(done), 64'd0);

        // Randomized transfers.
        for (int i = 0; i < 5; i++) begin
            mem_salt = $urandom;
            rv.src = 26'($urandom);
            rv.dst = 26'($urandom);
            rv.num = $urandom_range(1, 4);
            rv.ws = $urandom_range(0, 2);
            rv.lat = $urandom_range(0, 4);
            rv.abort_after = 0;
            rv.poke = 0;
            rv.exp_blocks = rv.num;
            rv.exp_aborted = 0;
            do_xfer(rv, 10 + i);
        end

        // Reset while a write is stalled in WR_HI.
        mem_salt = 32'h0;
        ws = 3; des_lat = 1;
        wb = wr_a_log.size();
        cfg_src_addr = 26'h0100000; cfg_dst_addr = 26'h0200000; cfg_num_blocks = 16'd1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 500 && !seen; cyc++) begin
            @(negedge clk);
            if (master_write) seen = 1;
        end
        check("rstw_reach_write", 64'(seen), 64'd1);
        check("rstw_addr", 64'(master_address), 64'h0200000);
        reset = 1'b1;
        #1;
        check("rstw_write_drop", 64'(master_write), 64'd0);
        check("rstw_busy_drop", 64'(busy), 64'd0);
        check("rstw_blocks", 64'(blocks_done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstw_no_write", 64'(wr_a_log.size() - wb), 64'd0);
        check("rstw_no_done", 64'(done), 64'd0);
        do_xfer(vecs[0], 20);

        check("bus_stable", 64'(stab_err), 64'd0);
        check("rd_wr_overlap", 64'(overlap), 64'd0);
        check("des_data_stable", 64'(des_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
